trigger_scheduler: RTL and testbench
====================================

Name: trigger_scheduler

Overview:
- Sequences the single board trigger output on behalf of two requesters: the active-low push button and an external/software request strobe.
- Performs fixed-priority arbitration, then runs a programmable burst of fixed-width pulses followed by a holdoff (re-arm lockout) window.
- Requests that arrive while busy are dropped and counted.
- Sits between the DE0 input pins / control logic and the downstream DDS/FPGA trigger input.

Parameters:
- CNT_W, 32, width of all length counters and length config ports.
- MISS_W, 8, width of the saturating missed-request counter.

Ports:
- int_clock  input  1  system clock (50 MHz board clock).
- reset_n  input  1  asynchronous active-low reset.
- push_button_n  input  1  raw active-low push button; asynchronous, unsynchronised.
- req_ext  input  1  synchronous request strobe; one cycle high = one request.
- arm  input  1  level; when 0, no new request is granted (in-flight sequence completes).
- pulse_len  input  CNT_W  pulse high time in cycles; 0 treated as 1.
- gap_len  input  CNT_W  low time between burst pulses in cycles; 0 treated as 1.
- burst_cnt  input  8  pulses per sequence; 0 treated as 1.
- holdoff_len  input  CNT_W  lockout after last pulse in cycles; 0 means no holdoff.
- trigger_out  output  1  registered trigger pulse output.
- trig_flag  output  1  busy: high from grant until holdoff ends.
- grant_src  output  1  source of current/last grant: 0 = button, 1 = ext.
- seq_done  output  1  one-cycle strobe when the sequence returns to IDLE.
- missed_cnt  output  MISS_W  saturating count of dropped requests.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM = IDLE; synchroniser flops = 1 (button released); counters = 0.
- Button path:
  - 2-flop synchroniser s1→s2, then s3 = delayed s2.
  - btn_req = s3 & ~s2, i.e. a falling edge, one cycle only.
  - Holding the button generates exactly one request.
- Arbitration: evaluated in IDLE with arm=1.
  - btn_req has priority over req_ext.
  - If both occur in the same cycle: button granted, ext counted as missed.
- Latency:
  - req_ext high at edge N (IDLE, armed) → trigger_out=1, trig_flag=1 after edge N.
  - Button sampled low into s1 at edge N → trigger_out=1 after edge N+2.
- Config latch: pulse_len, gap_len, burst_cnt and holdoff_len are captured at grant, with the 0→1 substitutions applied. Changes mid-sequence have no effect.
- FSM states and transitions:
  - IDLE → PULSE on grant.
  - PULSE: trigger_out=1 for exactly pulse_len cycles. Then:
    - → GAP if pulses remaining > 0;
    - → HOLDOFF if holdoff_len > 0;
    - → IDLE otherwise.
  - GAP: trigger_out=0 for exactly gap_len cycles, then → PULSE.
  - HOLDOFF: trigger_out=0 for holdoff_len cycles, then → IDLE.
  - trig_flag = 1 in every state except IDLE.
- seq_done: pulses for one cycle on the transition into IDLE. The scheduler can grant a new request in the first IDLE cycle (same cycle seq_done is high).
- Dropped requests:
  - Any btn_req or req_ext while not in IDLE, or while arm=0, increments missed_cnt.
  - Two simultaneous dropped requests count +2.
  - missed_cnt saturates at 2^MISS_W−1 and never wraps.
  - missed_cnt clears only on reset.
- arm deasserted mid-sequence: the current sequence finishes normally.
- reset_n asserted mid-pulse: trigger_out drops immediately (async); FSM returns to IDLE.
- Counter arithmetic:
  - Down-counters load the latched length − 1 and terminate at 0.
  - No counter ever wraps.
  - Burst counter is 8-bit and decrements at the end of each PULSE.

Optional Feature:
- Macro: TRIG_DELAY_EN.
- When defined:
  - Adds input port delay_len (CNT_W), latched at grant.
  - Adds state DELAY between IDLE and the first PULSE. trigger_out=0 for delay_len cycles; delay_len=0 skips DELAY entirely.
  - trig_flag is high during DELAY.
  - Requests during DELAY are counted as missed.
- When undefined: no delay_len port, no DELAY state; grant goes directly to PULSE with the latency above.

Test Plan:
- Reset then req_ext 1 cycle, pulse_len=25, burst_cnt=1, holdoff_len=100 → trigger_out high exactly 25 cycles starting 1 cycle after the strobe; trig_flag high 125 cycles; seq_done once; missed_cnt=0.
- push_button_n held low 1000 cycles, pulse_len=4, holdoff_len=0 → exactly one 4-cycle pulse, starting 3 cycles after button low; grant_src=0.
- burst_cnt=3, pulse_len=2, gap_len=5, holdoff_len=10 → trigger_out pattern 2 high / 5 low / 2 high / 5 low / 2 high, then 10 cycles busy low, then IDLE.
- Button edge and req_ext in the same cycle → grant_src=0, missed_cnt=1; five further req_ext during holdoff → missed_cnt=6; with MISS_W=8, 300 dropped requests → missed_cnt=255.
- pulse_len=0, burst_cnt=0, arm=0 then req_ext → no pulse, missed_cnt+1; then arm=1, req_ext → single 1-cycle pulse.
- reset_n low at cycle 10 of a 25-cycle pulse → trigger_out and trig_flag 0 immediately; after release a new req_ext gives a full 25-cycle pulse. With TRIG_DELAY_EN and delay_len=7: rising edge of trigger_out 7 cycles later than without the macro.

Source files
------------

// File: rtl/trigger_scheduler_if.sv
// ============================================================================
//  Module      : trigger_scheduler_if
//  Description : Request/config/status bundle of the trigger scheduler.
//                Carries delay_len only when TRIG_DELAY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trigger_scheduler_if #(
  parameter int CNT_W  = 32,
  parameter int MISS_W = 8
);
  logic              req_ext;
  logic              arm;
  logic [CNT_W-1:0]  pulse_len;
  logic [CNT_W-1:0]  gap_len;
  logic [7:0]        burst_cnt;
  logic [CNT_W-1:0]  holdoff_len;
`ifdef TRIG_DELAY_EN
  logic [CNT_W-1:0]  delay_len;
`endif
  logic              trigger_out;
  logic              trig_flag;
  logic              grant_src;
  logic              seq_done;
  logic [MISS_W-1:0] missed_cnt;

  modport master (
`ifdef TRIG_DELAY_EN
    output delay_len,
`endif
    output req_ext, arm, pulse_len, gap_len, burst_cnt, holdoff_len,
    input  trigger_out, trig_flag, grant_src, seq_done, missed_cnt
  );

  modport slave (
`ifdef TRIG_DELAY_EN
    input  delay_len,
`endif
    input  req_ext, arm, pulse_len, gap_len, burst_cnt, holdoff_len,
    output trigger_out, trig_flag, grant_src, seq_done, missed_cnt
  );
endinterface

`default_nettype wire

// File: rtl/trigger_scheduler.sv
// ============================================================================
//  Module      : trigger_scheduler
//  Description : Arbitrates button / external trigger requests and runs a
//                pulse burst plus holdoff window. Optional macro
//                TRIG_DELAY_EN adds a pre-burst DELAY state (delay_len).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_scheduler #(
  parameter int CNT_W  = 32,
  parameter int MISS_W = 8
) (
  input  wire                int_clock,
  input  wire                reset_n,
  input  wire                push_button_n,
  trigger_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_GAP     = 3'd2,
`ifdef TRIG_DELAY_EN
    S_DELAY   = 3'd4,
`endif
    S_HOLDOFF = 3'd3
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [7:0]        burst_left, burst_nx;
  logic [CNT_W-1:0]  pulse_q, pulse_nx;
  logic [CNT_W-1:0]  gap_q, gap_nx;
  logic [CNT_W-1:0]  holdoff_q, holdoff_nx;
  logic              src_q, src_nx;
  logic              trigger_q, trig_flag_q, seq_done_q;
  logic [MISS_W-1:0] missed_q, missed_nx;

  logic              s1, s2, s3;
  logic              btn_req;
  logic              can_grant, grant;
  logic              drop_btn, drop_ext;
  logic [1:0]        miss_inc;
  logic [MISS_W:0]   miss_sum;
  logic [CNT_W-1:0]  pulse_eff, gap_eff;
  logic [7:0]        burst_eff;

  // Button: two-flop synchroniser plus one delay flop for falling-edge detect
  always_ff @(posedge int_clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= push_button_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign btn_req   = s3 & ~s2;

  assign can_grant = (state == S_IDLE) && bus.arm;
  assign grant     = can_grant && (btn_req || bus.req_ext);
  assign drop_btn  = btn_req && !can_grant;
  // The external strobe loses to a simultaneous button edge
  assign drop_ext  = bus.req_ext && !(can_grant && !btn_req);

  assign miss_inc  = {1'b0, drop_btn} + {1'b0, drop_ext};
  assign miss_sum  = {1'b0, missed_q} + {{(MISS_W-1){1'b0}}, miss_inc};
  assign missed_nx = miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];

  assign pulse_eff = (bus.pulse_len == '0) ? CNT_ONE : bus.pulse_len;
  assign gap_eff   = (bus.gap_len == '0) ? CNT_ONE : bus.gap_len;
  assign burst_eff = (bus.burst_cnt == 8'd0) ? 8'd1 : bus.burst_cnt;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    burst_nx   = burst_left;
    pulse_nx   = pulse_q;
    gap_nx     = gap_q;
    holdoff_nx = holdoff_q;
    src_nx     = src_q;

    case (state)
      S_IDLE: begin
        if (grant) begin
          src_nx     = ~btn_req;
          pulse_nx   = pulse_eff;
          gap_nx     = gap_eff;
          holdoff_nx = bus.holdoff_len;
          burst_nx   = burst_eff;
          state_nx   = S_PULSE;
          cnt_nx     = pulse_eff - CNT_ONE;
`ifdef TRIG_DELAY_EN
          if (bus.delay_len != '0) begin
            state_nx = S_DELAY;
            cnt_nx   = bus.delay_len - CNT_ONE;
          end
`endif
        end
      end

`ifdef TRIG_DELAY_EN
      S_DELAY: begin
        if (cnt == '0) begin
          state_nx = S_PULSE;
          cnt_nx   = pulse_q - CNT_ONE;
        end else begin
          cnt_nx   = cnt - CNT_ONE;
        end
      end
`endif

      S_PULSE: begin
        if (cnt == '0) begin
          burst_nx = burst_left - 8'd1;
          if (burst_left != 8'd1) begin
            state_nx = S_GAP;
            cnt_nx   = gap_q - CNT_ONE;
          end else if (holdoff_q != '0) begin
            state_nx = S_HOLDOFF;
            cnt_nx   = holdoff_q - CNT_ONE;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end

      S_GAP: begin
        if (cnt == '0) begin
          state_nx = S_PULSE;
          cnt_nx   = pulse_q - CNT_ONE;
        end else begin
          cnt_nx   = cnt - CNT_ONE;
        end
      end

      S_HOLDOFF: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx   = cnt - CNT_ONE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge int_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      burst_left  <= 8'd0;
      pulse_q     <= '0;
      gap_q       <= '0;
      holdoff_q   <= '0;
      src_q       <= 1'b0;
      trigger_q   <= 1'b0;
      trig_flag_q <= 1'b0;
      seq_done_q  <= 1'b0;
      missed_q    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      burst_left  <= burst_nx;
      pulse_q     <= pulse_nx;
      gap_q       <= gap_nx;
      holdoff_q   <= holdoff_nx;
      src_q       <= src_nx;
      trigger_q   <= (state_nx == S_PULSE);
      trig_flag_q <= (state_nx != S_IDLE);
      seq_done_q  <= (state != S_IDLE) && (state_nx == S_IDLE);
      missed_q    <= missed_nx;
    end
  end

  assign bus.trigger_out = trigger_q;
  assign bus.trig_flag   = trig_flag_q;
  assign bus.grant_src   = src_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.missed_cnt  = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_scheduler.sv
// ============================================================================
//  Module      : tb_trigger_scheduler
//  Description : Scoreboard bench for trigger_scheduler (honours TRIG_DELAY_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_scheduler;
  localparam int CNT_W  = 32;
  localparam int MISS_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pb_n  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int pulses;
    int high;
    int busy;
    int src;
    int lat;
    int mark;
  } exp_t;
  exp_t sb[$];

  trigger_scheduler_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus();

  trigger_scheduler #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .int_clock     (clk),
    .reset_n       (rst_n),
    .push_button_n (pb_n),
    .bus           (bus.slave)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: measures each sequence and compares it on seq_done
  int m_pulses, m_high, m_busy, m_first;
  bit in_seq  = 1'b0;
  bit prev_hi = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_seq  = 1'b0;
      prev_hi = 1'b0;
    end else begin
      if (bus.trig_flag && !in_seq) begin
        in_seq   = 1'b1;
        m_pulses = 0;
        m_high   = 0;
        m_busy   = 0;
        m_first  = -1;
      end
      if (in_seq) begin
        if (bus.trig_flag) m_busy++;
        if (bus.trigger_out) begin
          m_high++;
          if (!prev_hi) m_pulses++;
          if (m_first < 0) m_first = cyc;
        end
      end
      prev_hi = bus.trigger_out;
      if (bus.seq_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_seq_done: got seq_done at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_count", m_pulses, e.pulses);
          chk("high_cycles", m_high, e.high);
          chk("busy_cycles", m_busy, e.busy);
          chk("grant_src", int'(bus.grant_src), e.src);
          chk("latency", m_first - e.mark, e.lat);
        end
        in_seq = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ext_pulse();
    bus.req_ext = 1'b1;
    tick(1);
    bus.req_ext = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int g, input int b, input int h);
    bus.pulse_len   = p;
    bus.gap_len     = g;
    bus.burst_cnt   = 8'(b);
    bus.holdoff_len = h;
  endtask

  task automatic expect_seq(input int p, input int h, input int b, input int s, input int l);
    exp_t e;
    e.pulses = p;
    e.high   = h;
    e.busy   = b;
    e.src    = s;
    e.lat    = l;
    e.mark   = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.seq_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no seq_done in %0d cycles, expected seq_done", name, budget);
    end
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_ext = 1'b0;
    bus.arm     = 1'b1;
`ifdef TRIG_DELAY_EN
    bus.delay_len = '0;
`endif
    set_cfg(1, 1, 1, 0);

    // Reset state
    #25;
    chk("rst_trigger_out", int'(bus.trigger_out), 0);
    chk("rst_trig_flag",   int'(bus.trig_flag), 0);
    chk("rst_grant_src",   int'(bus.grant_src), 0);
    chk("rst_seq_done",    int'(bus.seq_done), 0);
    chk("rst_missed_cnt",  int'(bus.missed_cnt), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single ext pulse with holdoff
    set_cfg(25, 1, 1, 100);
    expect_seq(1, 25, 125, 1, 1);
    ext_pulse();
    wait_done(200, "ext_single");
    chk("t1_missed", int'(bus.missed_cnt), 0);

    // Held button gives exactly one request
    set_cfg(4, 1, 1, 0);
    expect_seq(1, 4, 4, 0, 3);
    pb_n = 1'b0;
    tick(1000);
    pb_n = 1'b1;
    tick(5);
    chk("t2_missed", int'(bus.missed_cnt), 0);

    // Burst of three with gaps and holdoff
    set_cfg(2, 5, 3, 10);
    expect_seq(3, 6, 26, 1, 1);
    ext_pulse();
    wait_done(100, "burst");

    // Simultaneous button edge and ext strobe, then strobes during holdoff
    set_cfg(3, 1, 1, 20);
    expect_seq(1, 3, 23, 0, 3);
    pb_n = 1'b0;
    tick(2);
    bus.req_ext = 1'b1;
    tick(1);
    bus.req_ext = 1'b0;
    chk("t4_missed_tie", int'(bus.missed_cnt), 1);
    tick(4);
    repeat (5) begin
      ext_pulse();
      tick(1);
    end
    wait_done(100, "tie");
    pb_n = 1'b1;
    tick(3);
    chk("t4_missed_holdoff", int'(bus.missed_cnt), 6);

    // Disarmed request is dropped; zero lengths act as one
    bus.arm = 1'b0;
    set_cfg(0, 0, 0, 0);
    ext_pulse();
    tick(10);
    chk("t5_missed_disarmed", int'(bus.missed_cnt), 7);
    chk("t5_idle_flag", int'(bus.trig_flag), 0);
    bus.arm = 1'b1;
    expect_seq(1, 1, 1, 1, 1);
    ext_pulse();
    wait_done(20, "min_pulse");
    chk("t5_missed_after", int'(bus.missed_cnt), 7);

    // Saturation of the missed counter
    bus.arm     = 1'b0;
    bus.req_ext = 1'b1;
    tick(300);
    bus.req_ext = 1'b0;
    tick(2);
    chk("t6_missed_sat", int'(bus.missed_cnt), 255);
    bus.arm = 1'b1;

    // Asynchronous reset mid-pulse
    set_cfg(25, 1, 1, 0);
    ext_pulse();
    tick(10);
    chk("t7_pulse_active", int'(bus.trigger_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_trigger", int'(bus.trigger_out), 0);
    chk("t7_async_flag",    int'(bus.trig_flag), 0);
    chk("t7_async_missed",  int'(bus.missed_cnt), 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    expect_seq(1, 25, 25, 1, 1);
    ext_pulse();
    wait_done(60, "post_reset");

    // Pre-burst delay (plain pulse when the delay feature is absent)
`ifdef TRIG_DELAY_EN
    bus.delay_len = 7;
    expect_seq(1, 25, 32, 1, 8);
`else
    expect_seq(1, 25, 25, 1, 1);
`endif
    ext_pulse();
    wait_done(80, "delay");
    tick(5);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
